// File: rtl/peripheral_burst_memory.sv
// Wishbone-B4 registered-feedback memory slave: classic, constant and incrementing
// (linear/wrap4/8/16) bursts with range error. Optional first-beat wait states: BIU_MEM_WAIT_EN.
//
// state | meaning
// IDLE  | no beat in flight; a request latches the start address
// WAIT  | first-beat wait states (BIU_MEM_WAIT_EN builds only)
// BEAT  | ack_o or err_o is high for the current beat
module peripheral_burst_memory #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  input  logic [AW-1:0]   adr_i,
  input  logic [DW-1:0]   dat_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic [2:0]      cti_i,
  input  logic [1:0]      bte_i,
  output logic [DW-1:0]   dat_o,
  output logic            ack_o,
  output logic            err_o,
  output logic            sig_read,
  output logic            sig_write
);

  localparam int NB   = DW / 8;
  localparam int OFFS = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW   = AW - OFFS;
  localparam int MW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;

  state_t          state_q;
  logic [IW-1:0]   adr_q;
  logic            ack_q;
  logic            err_q;
  logic [DW-1:0]   dat_q;
  logic [DW-1:0]   mem [DEPTH];

  logic            req;
  logic            wr_en;
  logic            rd_ok;
  logic [IW-1:0]   adr_in_idx;
  logic [IW-1:0]   nxt_idx_d;
  logic [IW-1:0]   rd_idx_d;
  logic [DW-1:0]   wr_word;
  logic [DW-1:0]   rd_word;
  logic            unused_bits;

  assign req        = cyc_i & stb_i;
  assign adr_in_idx = adr_i[AW-1:OFFS];
  assign wr_en      = ack_q & req & we_i;
  assign unused_bits = ^{adr_i, WAIT_CYCLES[0]};

`ifdef BIU_MEM_WAIT_EN
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt_q;
`endif

  // Wrap bursts only advance the low index bits; upper bits stay put.
  always_comb begin
    nxt_idx_d = adr_q;
    if (cti_i == 3'b010) begin
      case (bte_i)
        2'b00:   nxt_idx_d      = adr_q + IW'(1);
        2'b01:   nxt_idx_d[1:0] = adr_q[1:0] + 2'd1;
        2'b10:   nxt_idx_d[2:0] = adr_q[2:0] + 3'd1;
        default: nxt_idx_d[3:0] = adr_q[3:0] + 4'd1;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      IDLE:    rd_idx_d = adr_in_idx;
      BEAT:    rd_idx_d = nxt_idx_d;
      default: rd_idx_d = adr_q;
    endcase
  end

  assign rd_ok = (rd_idx_d < IW'(DEPTH));

  always_comb begin
    wr_word = mem[adr_q[MW-1:0]];
    for (int b = 0; b < NB; b++) begin
      if (sel_i[b]) wr_word[8*b +: 8] = dat_i[8*b +: 8];
    end
  end

  // Forward the word being written so a following beat to it sees the new data.
  assign rd_word = (wr_en && (rd_idx_d == adr_q)) ? wr_word : mem[rd_idx_d[MW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[adr_q[MW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
`ifdef BIU_MEM_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req) begin
            adr_q <= adr_in_idx;
`ifdef BIU_MEM_WAIT_EN
            if (WAIT_CYCLES > 0) begin
              state_q <= WAIT;
              cnt_q   <= CW'(WAIT_CYCLES - 1);
            end else begin
              state_q <= BEAT;
              ack_q   <= rd_ok;
              err_q   <= ~rd_ok;
              dat_q   <= rd_ok ? rd_word : '0;
            end
`else
            state_q <= BEAT;
            ack_q   <= rd_ok;
            err_q   <= ~rd_ok;
            dat_q   <= rd_ok ? rd_word : '0;
`endif
          end
        end
`ifdef BIU_MEM_WAIT_EN
        WAIT: begin
          if (!req) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            state_q <= BEAT;
            ack_q   <= rd_ok;
            err_q   <= ~rd_ok;
            dat_q   <= rd_ok ? rd_word : '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
`endif
        BEAT: begin
          if (req && (cti_i == 3'b001 || cti_i == 3'b010)) begin
            adr_q <= nxt_idx_d;
            ack_q <= rd_ok;
            err_q <= ~rd_ok;
            dat_q <= rd_ok ? rd_word : '0;
          end else begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign sig_read  = ack_q & ~we_i;
  assign sig_write = ack_q & we_i;

endmodule

// File: tb/tb_peripheral_burst_memory.sv
// Scoreboard bench for peripheral_burst_memory: a word-array reference model predicts each
// beat's response at issue time; a negedge monitor pops and compares every presented beat.
module tb_peripheral_burst_memory;

  localparam int DEPTH = 256;
  localparam int WAIT_CYCLES = 2;
`ifdef BIU_MEM_WAIT_EN
  localparam int LAT = (WAIT_CYCLES > 0) ? WAIT_CYCLES + 1 : 1;
`else
  localparam int LAT = 1;
`endif

  logic        clk, rst, cyc, stb, we;
  logic [31:0] adr, dat_w;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_o;
  logic        ack_o, err_o, sig_read, sig_write;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          err;
    bit          we;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] model_mem [DEPTH];

  peripheral_burst_memory #(.DW(32), .AW(32), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(dat_w), .sel_i(sel), .cti_i(cti), .bte_i(bte), .dat_o(dat_o),
    .ack_o(ack_o), .err_o(err_o), .sig_read(sig_read), .sig_write(sig_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // Burst address rules: constant holds, linear steps, wrap stays inside an aligned block.
  function automatic logic [29:0] next_idx(input logic [29:0] idx, input logic [2:0] kind,
                                           input logic [1:0] b);
    int unsigned w;
    int unsigned i;
    if (kind != 3'b010) return idx;
    if (b == 2'b00) return idx + 30'd1;
    w = 2 << b;
    i = 32'(idx);
    return 30'((i - i % w) + (i + 1) % w);
  endfunction

  task automatic model_beat(input logic [29:0] idx, input bit w, input logic [31:0] d,
                            input logic [3:0] s);
    exp_t e;
    e.err  = (idx >= 30'(DEPTH));
    e.we   = w;
    e.data = '0;
    if (!e.err) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) model_mem[idx[7:0]][8*b +: 8] = d[8*b +: 8];
      end else begin
        e.data = model_mem[idx[7:0]];
      end
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && cyc && stb && (ack_o || err_o)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {ack_o, err_o}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("beat_err", {ack_o, err_o}, {~e.err, e.err});
        if (e.err) begin
          chk("err_dat_sig", {dat_o, sig_read, sig_write}, 34'd0);
        end else begin
          chk("beat_sig", {sig_read, sig_write}, {~e.we, e.we});
          if (!e.we) chk("read_data", dat_o, e.data);
        end
      end
    end
  end

  // we_mode: 0 read, 1 write, 2 random per beat, 3 write/read alternating.
  // dmode: 0 random data+sel, 1 random data full sel, 2 fixed fdat/fsel.
  task automatic do_txn(input int n, input logic [2:0] kind, input logic [1:0] bte_v,
                        input logic [31:0] a0, input int we_mode, input int stop_at,
                        input bit use_rst, input int dmode, input logic [31:0] fdat,
                        input logic [3:0] fsel);
    logic [29:0] idx;
    logic [29:0] ib [256];
    bit          wb [256];
    logic [31:0] db [256];
    logic [3:0]  sb [256];
    logic [2:0]  cb [256];
    int committed;
    int lat;
    idx = a0[31:2];
    committed = (stop_at > 0) ? stop_at : n;
    for (int i = 0; i < n; i++) begin
      case (we_mode)
        0: wb[i] = 1'b0;
        1: wb[i] = 1'b1;
        2: wb[i] = 1'($urandom_range(0, 1));
        default: wb[i] = (i % 2 == 0);
      endcase
      db[i] = (dmode == 2) ? fdat : $urandom;
      sb[i] = (dmode == 2) ? fsel : ((dmode == 1) ? 4'hF : 4'($urandom));
      cb[i] = (n == 1) ? kind : ((i == n - 1) ? 3'b111 : kind);
      ib[i] = idx;
      if (i < committed) model_beat(idx, wb[i], db[i], sb[i]);
      idx = next_idx(idx, kind, bte_v);
    end
    cyc = 1'b1; stb = 1'b1; bte = bte_v;
    we = wb[0]; dat_w = db[0]; sel = sb[0]; cti = cb[0]; adr = {ib[0], 2'b00};
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(ack_o || err_o) && lat < 20);
    chk("first_ack_latency", lat, LAT);
    if (lat >= 20) begin
      cyc = 1'b0; stb = 1'b0;
      return;
    end
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      if (stop_at == i && !use_rst) begin
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("abort_ack_drop", {ack_o, err_o}, 2'b00);
        return;
      end
      we = wb[i]; dat_w = db[i]; sel = sb[i]; cti = cb[i]; adr = {ib[i], 2'b00};
      if (stop_at == i && use_rst) begin
        rst = 1'b1;
        #1;
        chk("midburst_rst_outputs", {ack_o, err_o, sig_read, sig_write, dat_o}, 36'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", {ack_o, err_o}, 2'b00);
        return;
      end
      chk("burst_consecutive", ack_o | err_o, 1'b1);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    chk("ack_drop_after_last", {ack_o, err_o}, 2'b00);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    logic [31:0] a;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
    sel = '0; cti = '0; bte = '0;
    @(posedge clk); #1;
    chk("reset_outputs", {ack_o, err_o, sig_read, sig_write, dat_o}, 36'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_txn(DEPTH, 3'b010, 2'b00, 32'h0, 1, 0, 0, 1, 0, 0);

    do_txn(1, 3'b000, 2'b00, 32'h10, 1, 0, 0, 2, 32'hDEADBEEF, 4'hF);
    do_txn(1, 3'b000, 2'b00, 32'h10, 0, 0, 0, 0, 0, 0);
    chk("classic_read_const", model_mem[4], 32'hDEADBEEF);

    do_txn(1, 3'b000, 2'b00, 32'h20, 1, 0, 0, 2, 32'h11223344, 4'hF);
    do_txn(1, 3'b000, 2'b00, 32'h20, 1, 0, 0, 2, 32'h0000AB00, 4'b0010);
    do_txn(1, 3'b000, 2'b00, 32'h20, 0, 0, 0, 0, 0, 0);
    chk("byte_merge_const", model_mem[8], 32'h1122AB44);

    do_txn(4, 3'b010, 2'b01, 32'h18, 0, 0, 0, 0, 0, 0);
    do_txn(4, 3'b010, 2'b01, 32'h18, 1, 0, 0, 1, 0, 0);
    do_txn(4, 3'b010, 2'b01, 32'h18, 0, 0, 0, 0, 0, 0);

    do_txn(1, 3'b000, 2'b00, 32'h400, 0, 0, 0, 0, 0, 0);
    do_txn(1, 3'b000, 2'b00, 32'h400, 1, 0, 0, 1, 0, 0);
    do_txn(1, 3'b000, 2'b00, 32'h0, 0, 0, 0, 0, 0, 0);

    do_txn(4, 3'b010, 2'b00, 32'h3F8, 2, 0, 0, 0, 0, 0);
    do_txn(4, 3'b010, 2'b00, 32'h3F8, 0, 0, 0, 0, 0, 0);

    do_txn(6, 3'b001, 2'b00, 32'h40, 3, 0, 0, 0, 0, 0);
    do_txn(6, 3'b001, 2'b00, 32'h44, 2, 0, 0, 0, 0, 0);
    do_txn(8, 3'b010, 2'b11, 32'h7C, 3, 0, 0, 0, 0, 0);

    do_txn(5, 3'b010, 2'b00, 32'h80, 1, 2, 0, 1, 0, 0);
    do_txn(5, 3'b010, 2'b00, 32'h80, 0, 0, 0, 0, 0, 0);
    do_txn(5, 3'b010, 2'b10, 32'h90, 1, 2, 1, 1, 0, 0);
    do_txn(5, 3'b010, 2'b10, 32'h90, 0, 0, 0, 0, 0, 0);

    for (int t = 0; t < 150; t++) begin
      k = int'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) a = 32'h400 + ($urandom_range(0, 255) << 2);
      else a = $urandom_range(0, 255) << 2;
      if (k == 0)
        do_txn(1, 3'b000, 2'b00, a, int'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
      else
        do_txn(int'($urandom_range(2, 8)), (k == 1) ? 3'b001 : 3'b010,
               2'($urandom_range(0, 3)), a, int'($urandom_range(0, 3)), 0, 0, 0, 0, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
